gpr_write_arbiter: RTL and testbench
====================================

Name: gpr_write_arbiter

Overview:
- Shares the single GPR file write port between two writers:
  - Requester A: the in-order pipeline writeback stage.
  - Requester B: a multi-cycle unit such as mult/div or a late load.
- B results are queued in a small FIFO.
- A has priority, with a fairness rule so that a full FIFO always drains.
- Outputs are registered and drive the GPR file write_enable/write_addr/write_data directly.
- A query port reports whether a register has a queued write, so decode can stall.

Parameters:
- ADDR_WIDTH, 5, GPR address width.
- DATA_WIDTH, 32, GPR data width.
- FIFO_DEPTH, 4, B queue entries; power of two, at least 2.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset: asserted when 0, sampled on posedge clock.
- a_valid  in  1  writeback request from the pipeline.
- a_addr  in  ADDR_WIDTH  destination register for A.
- a_data  in  DATA_WIDTH  result for A.
- a_ready  out  1  A granted this cycle; combinational.
- b_valid  in  1  multi-cycle unit result valid.
- b_addr  in  ADDR_WIDTH  destination register for B.
- b_data  in  DATA_WIDTH  result for B.
- b_ready  out  1  FIFO can accept; equals !full from the registered count.
- query_addr  in  ADDR_WIDTH  register being checked by decode.
- query_pending  out  1  query_addr matches a valid FIFO entry; combinational.
- fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy; registered.
- write_enable  out  1  to GPR file; registered.
- write_addr  out  ADDR_WIDTH  to GPR file; registered.
- write_data  out  DATA_WIDTH  to GPR file; registered.

Behaviour:
Reset (reset==0 at posedge):
- Cleared: count, read/write pointers, write_enable, write_addr, write_data, last_grant (value A).
- FIFO contents are don't-care.
- Takes effect mid-operation: queued entries are discarded, and no write_enable pulse occurs in the cycle after reset.

Handshakes:
- A transfer occurs when a_valid && a_ready.
- B push occurs when b_valid && b_ready.
- Requesters hold addr/data stable while valid && !ready.

Grant, combinational, evaluated each cycle:
- grant_fifo = !empty && (!a_valid || (full && last_grant==A)).
- grant_a = a_valid && !grant_fifo.
- a_ready = grant_a.

Register update on posedge (reset deasserted):
- write_enable <= grant_a || grant_fifo.
- write_addr/write_data <= granted source; they hold their previous value when idle.
- last_grant <= A on grant_a, FIFO on grant_fifo, unchanged when idle.
- FIFO pop on grant_fifo; push on B handshake.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- b_ready depends only on the registered count; a pop in the same cycle does not raise it.

Address zero:
- A granted request with addr 0 is consumed (handshake completes and the pop/grant happens) but write_enable stays 0 next cycle.
- A B push with addr 0 is accepted and enqueued but never matches query_pending.

Latency:
- A accepted in cycle N gives write_enable=1 in N+1.
- B pushed into an empty FIFO in N is popped earliest in N+1 and written in N+2.
- The GPR file bypasses same-cycle writes, so an entry stops being pending once popped.

Fairness:
- With A continuously valid and the FIFO full, grants alternate A, FIFO, A, FIFO...
- When the FIFO is not full, A always wins.

query_pending:
- OR over valid entries of (entry_addr==query_addr && query_addr!=0).
- Excludes the output register.

Test Plan:
- Reset: hold reset=0 for 2 cycles while a_valid=1 and b_valid=1 → write_enable=0, fifo_count=0, a_ready=0; after release, a_valid=1, a_addr=3, a_data=0x11 → next cycle write_enable=1, write_addr=3, write_data=0x11.
- B path latency: FIFO empty, a_valid=0, push b_addr=7, b_data=0xDEAD in cycle N → query_pending(7)=1 in N+1; write 7←0xDEAD in N+2; fifo_count back to 0 and query_pending(7)=0 in N+2.
- Backpressure/fairness: a_valid held 1; push 4 B entries (addrs 1..4) → b_ready=0 once count=4; output sequence alternates A, B1, A, B2, ...; each B entry written exactly once, in order.
- Address zero: a_addr=0 granted → a_ready=1, write_enable=0 next cycle; b_addr=0 queued → popped, no write, query_pending(0)=0.
- Simultaneous push/pop: count=2, a_valid=0, b push in the same cycle as a pop → count stays 2, order preserved across pointer wrap over 10+ entries.
- Reset mid-drain: FIFO holds 3 entries, assert reset=0 for one cycle → count=0, write_enable=0 the following cycle, no stale entry ever written.

Source files
------------

// File: rtl/gpr_write_arbiter.sv
// Arbitrates the single GPR write port between the in-order writeback (A) and a
// queued multi-cycle result stream (B), with a fairness rule so a full queue drains.
module gpr_write_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          a_valid,
  input  logic [ADDR_WIDTH-1:0]         a_addr,
  input  logic [DATA_WIDTH-1:0]         a_data,
  output logic                          a_ready,
  input  logic                          b_valid,
  input  logic [ADDR_WIDTH-1:0]         b_addr,
  input  logic [DATA_WIDTH-1:0]         b_data,
  output logic                          b_ready,
  input  logic [ADDR_WIDTH-1:0]         query_addr,
  output logic                          query_pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          write_enable,
  output logic [ADDR_WIDTH-1:0]         write_addr,
  output logic [DATA_WIDTH-1:0]         write_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {GRANT_A = 1'b0, GRANT_FIFO = 1'b1} grant_e;

  grant_e                  last_grant;
  logic [ADDR_WIDTH-1:0]   entry_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   entry_data [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [CNT_W-1:0]        count;
  logic [PTR_W-1:0]        slot_ofs;
  logic                    empty;
  logic                    full;
  logic                    grant_fifo;
  logic                    grant_a;
  logic                    push;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic [DATA_WIDTH-1:0]   head_data;

  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  // No grants while reset is held, so nothing is consumed during reset.
  assign grant_fifo = reset && !empty && (!a_valid || (full && last_grant == GRANT_A));
  assign grant_a    = reset && a_valid && !grant_fifo;
  assign a_ready    = grant_a;
  assign b_ready    = !full;
  assign push       = b_valid && b_ready;
  assign head_addr  = entry_addr[rd_ptr];
  assign head_data  = entry_data[rd_ptr];
  assign fifo_count = count;

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    query_pending = 1'b0;
    slot_ofs      = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot_ofs = PTR_W'(i) - rd_ptr;
      if (({1'b0, slot_ofs} < count) && (entry_addr[i] == query_addr) && (query_addr != '0))
        query_pending = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      entry_addr[wr_ptr] <= b_addr;
      entry_data[wr_ptr] <= b_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      last_grant   <= GRANT_A;
    end else begin
      // Register zero is architecturally constant: consume the request, suppress the write.
      write_enable <= (grant_a && a_addr != '0) || (grant_fifo && head_addr != '0);
      if (grant_a) begin
        write_addr <= a_addr;
        write_data <= a_data;
        last_grant <= GRANT_A;
      end else if (grant_fifo) begin
        write_addr <= head_addr;
        write_data <= head_data;
        last_grant <= GRANT_FIFO;
        rd_ptr     <= rd_ptr + PTR_W'(1);
      end
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push, grant_fifo})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Self-checking bench for gpr_write_arbiter: per-scenario tasks plus a write-port
// scoreboard fed from observed A/B handshakes.
module tb_gpr_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic [AW-1:0] query_addr;
  logic          query_pending;
  logic [CW-1:0] fifo_count;
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;

  int checks = 0;
  int passes = 0;
  logic [AW+DW-1:0] a_q[$];
  logic [AW+DW-1:0] b_q[$];

  gpr_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .query_addr(query_addr), .query_pending(query_pending), .fifo_count(fifo_count),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Every GPR write must be the head of the A queue or the head of the B queue.
  always @(negedge clock) begin
    logic [AW+DW-1:0] exp_w;
    if (write_enable === 1'b1) begin
      checks++;
      if (a_q.size() > 0 && a_q[0] === {write_addr, write_data}) begin
        void'(a_q.pop_front());
        passes++;
      end else if (b_q.size() > 0) begin
        exp_w = b_q.pop_front();
        if ({write_addr, write_data} !== exp_w)
          $display("FAIL write_order: got addr %0h data %0h required addr %0h data %0h",
                   write_addr, write_data, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
        else
          passes++;
      end else
        $display("FAIL unexpected_write: got addr %0h data %0h required no write",
                 write_addr, write_data);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h55;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h66; query_addr = '0;
    tick();
    tick();
    checks++; if (write_enable !== 1'b0) $display("FAIL rst_we: got %0b required 0", write_enable); else passes++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL rst_count: got %0d required 0", fifo_count); else passes++;
    checks++; if (a_ready !== 1'b0) $display("FAIL rst_a_ready: got %0b required 0", a_ready); else passes++;
    reset = 1'b1; a_addr = 5'd3; a_data = 32'h11; b_valid = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b1) $display("FAIL rst_release_a_ready: got %0b required 1", a_ready); else passes++;
    if (a_ready) a_q.push_back({a_addr, a_data});
    tick();
    a_valid = 1'b0;
    checks++; if (write_enable !== 1'b1) $display("FAIL first_we: got %0b required 1", write_enable); else passes++;
    checks++; if (write_addr !== 5'd3) $display("FAIL first_addr: got %0h required 3", write_addr); else passes++;
    checks++; if (write_data !== 32'h11) $display("FAIL first_data: got %0h required 11", write_data); else passes++;
  endtask

  task automatic test_b_latency();
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hDEAD; query_addr = 5'd7;
    #1;
    checks++; if (b_ready !== 1'b1) $display("FAIL lat_b_ready: got %0b required 1", b_ready); else passes++;
    if (b_ready) b_q.push_back({b_addr, b_data});
    tick();
    b_valid = 1'b0;
    #1;
    checks++; if (query_pending !== 1'b1) $display("FAIL lat_pending_n1: got %0b required 1", query_pending); else passes++;
    checks++; if (fifo_count !== 3'd1) $display("FAIL lat_count_n1: got %0d required 1", fifo_count); else passes++;
    checks++; if (write_enable !== 1'b0) $display("FAIL lat_we_n1: got %0b required 0", write_enable); else passes++;
    tick();
    checks++; if (write_enable !== 1'b1) $display("FAIL lat_we_n2: got %0b required 1", write_enable); else passes++;
    checks++; if (write_addr !== 5'd7) $display("FAIL lat_addr_n2: got %0h required 7", write_addr); else passes++;
    checks++; if (write_data !== 32'hDEAD) $display("FAIL lat_data_n2: got %0h required dead", write_data); else passes++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL lat_count_n2: got %0d required 0", fifo_count); else passes++;
    checks++; if (query_pending !== 1'b0) $display("FAIL lat_pending_n2: got %0b required 0", query_pending); else passes++;
  endtask

  task automatic test_addr_zero();
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hA000_0000;
    #1;
    checks++; if (a_ready !== 1'b1) $display("FAIL z_a_ready: got %0b required 1", a_ready); else passes++;
    tick();
    a_valid = 1'b0;
    checks++; if (write_enable !== 1'b0) $display("FAIL z_a_we: got %0b required 0", write_enable); else passes++;
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hB000_0000; query_addr = 5'd0;
    #1;
    checks++; if (b_ready !== 1'b1) $display("FAIL z_b_ready: got %0b required 1", b_ready); else passes++;
    tick();
    b_valid = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd1) $display("FAIL z_count: got %0d required 1", fifo_count); else passes++;
    checks++; if (query_pending !== 1'b0) $display("FAIL z_pending: got %0b required 0", query_pending); else passes++;
    tick();
    checks++; if (fifo_count !== 3'd0) $display("FAIL z_popped: got %0d required 0", fifo_count); else passes++;
    checks++; if (write_enable !== 1'b0) $display("FAIL z_b_we: got %0b required 0", write_enable); else passes++;
  endtask

  task automatic test_fairness();
    int nb = 0;
    logic exp_a, exp_b;
    for (int k = 0; k < 12; k++) begin
      a_valid = 1'b1; a_addr = AW'(16 + k); a_data = 32'hA000_0100 + DW'(k);
      b_valid = (nb < 8); b_addr = AW'(nb + 1); b_data = 32'hB000_0100 + DW'(nb + 1);
      query_addr = 5'd3;
      #1;
      exp_a = (k < 4) ? 1'b1 : (k % 2 == 1);
      exp_b = (k < 4) || (k % 2 == 1);
      checks++; if (a_ready !== exp_a) $display("FAIL fair_a_ready[%0d]: got %0b required %0b", k, a_ready, exp_a); else passes++;
      checks++; if (b_ready !== exp_b) $display("FAIL fair_b_ready[%0d]: got %0b required %0b", k, b_ready, exp_b); else passes++;
      if (k == 4) begin
        checks++; if (query_pending !== 1'b1) $display("FAIL fair_pending: got %0b required 1", query_pending); else passes++;
      end
      if (a_ready) a_q.push_back({a_addr, a_data});
      if (b_valid && b_ready) begin
        b_q.push_back({b_addr, b_data});
        nb++;
      end
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 20 && fifo_count != 3'd0; i++) tick();
    tick();
    checks++; if (fifo_count !== 3'd0) $display("FAIL fair_drain: got %0d required 0", fifo_count); else passes++;
    checks++; if (b_q.size() != 0) $display("FAIL fair_b_left: got %0d entries required 0", b_q.size()); else passes++;
  endtask

  task automatic test_push_pop();
    for (int k = 0; k < 2; k++) begin
      a_valid = 1'b1; a_addr = AW'(20 + k); a_data = 32'hA000_0200 + DW'(k);
      b_valid = 1'b1; b_addr = AW'(1 + k); b_data = 32'hB000_0200 + DW'(k);
      #1;
      if (a_ready) a_q.push_back({a_addr, a_data});
      if (b_ready) b_q.push_back({b_addr, b_data});
      tick();
    end
    a_valid = 1'b0;
    for (int k = 2; k < 14; k++) begin
      b_valid = 1'b1; b_addr = AW'(1 + k); b_data = 32'hB000_0200 + DW'(k);
      #1;
      checks++; if (fifo_count !== 3'd2) $display("FAIL pp_count[%0d]: got %0d required 2", k, fifo_count); else passes++;
      checks++; if (b_ready !== 1'b1) $display("FAIL pp_b_ready[%0d]: got %0b required 1", k, b_ready); else passes++;
      if (b_ready) b_q.push_back({b_addr, b_data});
      tick();
    end
    b_valid = 1'b0;
    for (int i = 0; i < 20 && fifo_count != 3'd0; i++) tick();
    tick();
    checks++; if (fifo_count !== 3'd0) $display("FAIL pp_drain: got %0d required 0", fifo_count); else passes++;
    checks++; if (b_q.size() != 0) $display("FAIL pp_b_left: got %0d entries required 0", b_q.size()); else passes++;
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < 3; k++) begin
      a_valid = 1'b1; a_addr = AW'(24 + k); a_data = 32'hA000_0300 + DW'(k);
      b_valid = 1'b1; b_addr = AW'(9 + k); b_data = 32'hB000_0300 + DW'(k);
      #1;
      if (a_ready) a_q.push_back({a_addr, a_data});
      if (b_ready) b_q.push_back({b_addr, b_data});
      tick();
    end
    checks++; if (fifo_count !== 3'd3) $display("FAIL mid_count_pre: got %0d required 3", fifo_count); else passes++;
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    tick();
    reset = 1'b1;
    b_q.delete();
    checks++; if (fifo_count !== 3'd0) $display("FAIL mid_count: got %0d required 0", fifo_count); else passes++;
    checks++; if (write_enable !== 1'b0) $display("FAIL mid_we: got %0b required 0", write_enable); else passes++;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (write_enable !== 1'b0) $display("FAIL mid_stale_we[%0d]: got %0b required 0", i, write_enable); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_b_latency();
    test_addr_zero();
    test_fairness();
    test_push_pop();
    test_reset_mid_drain();
    checks++; if (a_q.size() != 0) $display("FAIL a_left: got %0d entries required 0", a_q.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
